// File: rtl/mmio_uart_tx_pkg.sv
// Shared constants for the MMIO UART transmitter: register offsets, bit indices,
// serializer states and the STATUS word packer.
package mmio_uart_pkg;

  localparam logic [31:0] OFF_TXDATA = 32'h0000_0000;
  localparam logic [31:0] OFF_STATUS = 32'h0000_0004;
  localparam logic [31:0] OFF_CTRL   = 32'h0000_0008;

  localparam int ST_FULL      = 0;
  localparam int ST_EMPTY     = 1;
  localparam int ST_BUSY      = 2;
  localparam int ST_OVERFLOW  = 3;
  localparam int ST_COUNT_LSB = 8;

  localparam int CTRL_ENABLE  = 0;
  localparam int CTRL_FLUSH   = 1;
  localparam int CTRL_CLR_OVF = 2;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_START = 2'd1,
    S_DATA  = 2'd2,
    S_STOP  = 2'd3
  } tx_state_e;

  function automatic logic [31:0] pack_status(input logic       full,
                                              input logic       empty,
                                              input logic       busy_b,
                                              input logic       ovf,
                                              input logic [7:0] count);
    logic [31:0] s;
    s                       = 32'h0000_0000;
    s[ST_FULL]              = full;
    s[ST_EMPTY]             = empty;
    s[ST_BUSY]              = busy_b;
    s[ST_OVERFLOW]          = ovf;
    s[ST_COUNT_LSB +: 8]    = count;
    return s;
  endfunction

endpackage

// File: rtl/mmio_uart_tx_if.sv
// Data-memory port seen by the transmitter: store strobe, address, write data
// and the combinational status readback.
interface mmio_uart_tx_if;
  logic        MemWrite;
  logic [31:0] DataAdr;
  logic [31:0] WriteData;
  logic [31:0] ReadData;

  modport master (output MemWrite, output DataAdr, output WriteData, input ReadData);
  modport slave  (input MemWrite, input DataAdr, input WriteData, output ReadData);
endinterface

// File: rtl/mmio_uart_tx_sync_fifo.sv
// Single-clock FIFO with occupancy count and one-cycle flush; a push while full
// is accepted only when a pop happens on the same edge.
module sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 8
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         push_i,
  input  logic [WIDTH-1:0]             wdata_i,
  input  logic                         pop_i,
  input  logic                         flush_i,
  output logic [WIDTH-1:0]             rdata_o,
  output logic                         full_o,
  output logic                         empty_o,
  output logic [$clog2(DEPTH+1)-1:0]   count_o
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]    count_q, count_d;
  logic             do_push_s, do_pop_s;

  assign full_o  = (count_q == CW'(DEPTH));
  assign empty_o = (count_q == '0);
  assign rdata_o = mem_q[rd_ptr_q];
  assign count_o = count_q;

  // Pointer and count update; flush wins over any concurrent push.
  always_comb begin
    do_pop_s  = pop_i & ~empty_o;
    do_push_s = push_i & ~flush_i & (~full_o | do_pop_s);
    wr_ptr_d  = wr_ptr_q;
    rd_ptr_d  = rd_ptr_q;
    count_d   = count_q;
    if (flush_i) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      wr_ptr_d = do_push_s ? wr_ptr_q + AW'(1) : wr_ptr_q;
      rd_ptr_d = do_pop_s  ? rd_ptr_q + AW'(1) : rd_ptr_q;
      case ({do_push_s, do_pop_s})
        2'b10:   count_d = count_q + CW'(1);
        2'b01:   count_d = count_q - CW'(1);
        default: count_d = count_q;
      endcase
    end
  end

  // Control state register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage array; contents are meaningless outside the count window, so no reset.
  always_ff @(posedge clk) begin
    if (do_push_s) begin
      mem_q[wr_ptr_q] <= wdata_i;
    end
  end

endmodule

// File: rtl/mmio_uart_tx.sv
// MMIO 8N1 transmitter: decodes a 3-register window on the data-memory port,
// queues stored bytes in a FIFO and serializes them on a flopped tx line.
module mmio_uart_tx
  import mmio_uart_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR    = 32'hFFFF_0000,
  parameter int          DEPTH        = 8,
  parameter int          CLKS_PER_BIT = 16
) (
  input  logic          clk,
  input  logic          reset,
  mmio_uart_tx_if.slave bus,
  output logic          tx,
  output logic          busy
);
  localparam int            CW        = $clog2(DEPTH + 1);
  localparam int            BW        = $clog2(CLKS_PER_BIT);
  localparam logic [BW-1:0] BAUD_LAST = BW'(CLKS_PER_BIT - 1);

  logic          sel_txdata_s, sel_status_s, sel_ctrl_s;
  logic          wr_txdata_s, wr_ctrl_s, flush_s, clr_ovf_s;
  logic          fifo_full_s, fifo_empty_s, pop_s, can_pop_s, baud_end_s;
  logic [7:0]    fifo_rdata_s, count8_s;
  logic [CW-1:0] fifo_count_s;
  logic          enable_q, enable_d, overflow_q, overflow_d;
  tx_state_e     state_q, state_d;
  logic [BW-1:0] baud_q, baud_d;
  logic [2:0]    bit_q, bit_d;
  logic [7:0]    shreg_q, shreg_d;
  logic          tx_q, tx_d, busy_q, busy_d;
  logic          unused_wdata_s;

  assign sel_txdata_s   = (bus.DataAdr == BASE_ADDR + OFF_TXDATA);
  assign sel_status_s   = (bus.DataAdr == BASE_ADDR + OFF_STATUS);
  assign sel_ctrl_s     = (bus.DataAdr == BASE_ADDR + OFF_CTRL);
  assign wr_txdata_s    = bus.MemWrite & sel_txdata_s;
  assign wr_ctrl_s      = bus.MemWrite & sel_ctrl_s;
  assign flush_s        = wr_ctrl_s & bus.WriteData[CTRL_FLUSH];
  assign clr_ovf_s      = wr_ctrl_s & bus.WriteData[CTRL_CLR_OVF];
  assign unused_wdata_s = ^bus.WriteData[31:8];
  assign count8_s       = 8'(fifo_count_s);

  assign bus.ReadData = sel_status_s
                      ? pack_status(fifo_full_s, fifo_empty_s, busy_q, overflow_q, count8_s)
                      : 32'h0000_0000;
  assign tx   = tx_q;
  assign busy = busy_q;

  sync_fifo #(
    .WIDTH (8),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk     (clk),
    .reset   (reset),
    .push_i  (wr_txdata_s),
    .wdata_i (bus.WriteData[7:0]),
    .pop_i   (pop_s),
    .flush_i (flush_s),
    .rdata_o (fifo_rdata_s),
    .full_o  (fifo_full_s),
    .empty_o (fifo_empty_s),
    .count_o (fifo_count_s)
  );

  // CTRL side effects and the sticky overflow flag (a drop only when no pop frees a slot).
  always_comb begin
    enable_d   = enable_q;
    overflow_d = overflow_q;
    if (wr_ctrl_s) begin
      enable_d = bus.WriteData[CTRL_ENABLE];
    end else begin
      enable_d = enable_q;
    end
    if (clr_ovf_s) begin
      overflow_d = 1'b0;
    end else if (wr_txdata_s && fifo_full_s && !pop_s) begin
      overflow_d = 1'b1;
    end else begin
      overflow_d = overflow_q;
    end
  end

  // Serializer next state: baud counter paces each line phase, shreg feeds LSB first.
  always_comb begin
    state_d    = state_q;
    baud_d     = baud_q;
    bit_d      = bit_q;
    shreg_d    = shreg_q;
    tx_d       = tx_q;
    pop_s      = 1'b0;
    baud_end_s = (baud_q == BAUD_LAST);
    can_pop_s  = enable_q & ~fifo_empty_s;
    case (state_q)
      S_IDLE: begin
        if (can_pop_s) begin
          pop_s   = 1'b1;
          state_d = S_START;
          baud_d  = '0;
          shreg_d = fifo_rdata_s;
          tx_d    = 1'b0;
        end else begin
          tx_d    = 1'b1;
        end
      end
      S_START: begin
        if (baud_end_s) begin
          state_d = S_DATA;
          baud_d  = '0;
          bit_d   = 3'd0;
          tx_d    = shreg_q[0];
          shreg_d = {1'b0, shreg_q[7:1]};
        end else begin
          baud_d  = baud_q + BW'(1);
        end
      end
      S_DATA: begin
        if (baud_end_s) begin
          baud_d = '0;
          if (bit_q == 3'd7) begin
            state_d = S_STOP;
            tx_d    = 1'b1;
          end else begin
            bit_d   = bit_q + 3'd1;
            tx_d    = shreg_q[0];
            shreg_d = {1'b0, shreg_q[7:1]};
          end
        end else begin
          baud_d = baud_q + BW'(1);
        end
      end
      S_STOP: begin
        if (baud_end_s) begin
          baud_d = '0;
          if (can_pop_s) begin
            pop_s   = 1'b1;
            state_d = S_START;
            shreg_d = fifo_rdata_s;
            tx_d    = 1'b0;
          end else begin
            state_d = S_IDLE;
            tx_d    = 1'b1;
          end
        end else begin
          baud_d = baud_q + BW'(1);
        end
      end
      default: begin
        state_d = S_IDLE;
        baud_d  = '0;
        tx_d    = 1'b1;
      end
    endcase
    busy_d = (state_d != S_IDLE);
  end

  // State register; reset drives the line idle-high asynchronously.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      enable_q   <= 1'b1;
      overflow_q <= 1'b0;
      state_q    <= S_IDLE;
      baud_q     <= '0;
      bit_q      <= 3'd0;
      shreg_q    <= 8'h00;
      tx_q       <= 1'b1;
      busy_q     <= 1'b0;
    end else begin
      enable_q   <= enable_d;
      overflow_q <= overflow_d;
      state_q    <= state_d;
      baud_q     <= baud_d;
      bit_q      <= bit_d;
      shreg_q    <= shreg_d;
      tx_q       <= tx_d;
      busy_q     <= busy_d;
    end
  end

endmodule

// File: tb/tb_mmio_uart_tx.sv
// Self-checking bench for mmio_uart_tx: random bytes are compared against an
// ideal 8N1 line timeline computed from frame start time and bit period.
module tb_mmio_uart_tx;
  localparam int          C    = 4;
  localparam int          D    = 8;
  localparam logic [31:0] BASE = 32'hFFFF_0000;
  localparam logic [31:0] A_TX = BASE;
  localparam logic [31:0] A_ST = BASE + 32'd4;
  localparam logic [31:0] A_CT = BASE + 32'd8;

  logic clk = 1'b0;
  logic reset;
  logic tx, busy;
  mmio_uart_tx_if bus_if ();

  mmio_uart_tx #(
    .BASE_ADDR    (BASE),
    .DEPTH        (D),
    .CLKS_PER_BIT (C)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus_if),
    .tx    (tx),
    .busy  (busy)
  );

  always #5 clk = ~clk;

  int         n_tests = 0;
  int         n_fail  = 0;
  int         cyc     = 0;
  logic [7:0] frames[$];
  int         line_start = 0;

  // Ideal line: frames back to back from line_start, each 10 bit periods.
  function automatic logic exp_tx(input int t);
    int rel, idx, ph;
    if (t < line_start) return 1'b1;
    rel = t - line_start;
    idx = rel / (10 * C);
    if (idx >= frames.size()) return 1'b1;
    ph = (rel % (10 * C)) / C;
    if (ph == 0) return 1'b0;
    if (ph == 9) return 1'b1;
    return frames[idx][ph-1];
  endfunction

  function automatic logic exp_busy(input int t);
    return (t >= line_start) && (t < line_start + 10 * C * frames.size());
  endfunction

  function automatic logic [31:0] exp_status(input int cnt, input bit bsy, input bit ovf);
    logic [31:0] s;
    s        = 32'h0;
    s[0]     = (cnt == D);
    s[1]     = (cnt == 0);
    s[2]     = bsy;
    s[3]     = ovf;
    s[15:8]  = 8'(cnt);
    return s;
  endfunction

  task automatic tick();
    @(posedge clk);
    cyc++;
    #1;
  endtask

  task automatic store(input logic [31:0] a, input logic [31:0] d);
    bus_if.MemWrite  = 1'b1;
    bus_if.DataAdr   = a;
    bus_if.WriteData = d;
    tick();
    bus_if.MemWrite  = 1'b0;
    bus_if.DataAdr   = 32'h0;
    bus_if.WriteData = 32'h0;
  endtask

  task automatic read_reg(input logic [31:0] a, output logic [31:0] v);
    bus_if.DataAdr = a;
    #1;
    v = bus_if.ReadData;
    bus_if.DataAdr = 32'h0;
  endtask

  task automatic test_reset();
    logic [31:0] v;
    reset = 1'b0;
    bus_if.MemWrite = 1'b0; bus_if.DataAdr = 32'h0; bus_if.WriteData = 32'h0;
    tick(); tick();
    n_tests++;
    if (tx !== 1'b1 || busy !== 1'b0) begin
      n_fail++; $display("FAIL reset_lines tx=%b busy=%b expected tx=1 busy=0", tx, busy);
    end
    reset = 1'b1;
    tick();
    read_reg(A_ST, v);
    n_tests++;
    if (v !== exp_status(0, 1'b0, 1'b0)) begin
      n_fail++; $display("FAIL reset_status got=%h expected=%h", v, exp_status(0, 1'b0, 1'b0));
    end
  endtask

  task automatic test_frames(input int n, input bit fixed_a5);
    logic [31:0] v;
    frames.delete();
    for (int i = 0; i < n; i++) frames.push_back((fixed_a5 && i == 0) ? 8'hA5 : 8'($urandom));
    line_start = cyc + 2;
    for (int t = 0; t < n * 10 * C + 2 * C; t++) begin
      if (t < n) store(A_TX, {24'($urandom), frames[t]});
      else tick();
      n_tests++;
      if (tx !== exp_tx(cyc) || busy !== exp_busy(cyc)) begin
        n_fail++;
        $display("FAIL frames cyc=%0d tx=%b busy=%b expected tx=%b busy=%b",
                 cyc, tx, busy, exp_tx(cyc), exp_busy(cyc));
      end
      if (t == 2 && n >= 3) begin
        read_reg(A_ST, v);
        n_tests++;
        if (v[15:8] !== 8'd2) begin
          n_fail++; $display("FAIL count_after_pop got=%0d expected=2", v[15:8]);
        end
      end
    end
    read_reg(A_ST, v);
    n_tests++;
    if (v !== exp_status(0, 1'b0, 1'b0)) begin
      n_fail++; $display("FAIL frames_end_status got=%h expected=%h", v, exp_status(0, 1'b0, 1'b0));
    end
  endtask

  task automatic test_overflow();
    logic [31:0] v;
    logic [7:0]  b;
    frames.delete();
    line_start = 1 << 30;
    store(A_CT, 32'h0);
    for (int i = 0; i < 9; i++) begin
      b = 8'($urandom);
      if (i < D) frames.push_back(b);
      store(A_TX, {24'h0, b});
      n_tests++;
      if (tx !== 1'b1 || busy !== 1'b0) begin
        n_fail++; $display("FAIL disabled_line tx=%b busy=%b expected tx=1 busy=0", tx, busy);
      end
    end
    read_reg(A_ST, v);
    n_tests++;
    if (v !== exp_status(D, 1'b0, 1'b1)) begin
      n_fail++; $display("FAIL overflow_status got=%h expected=%h", v, exp_status(D, 1'b0, 1'b1));
    end
    store(A_CT, 32'h4);
    read_reg(A_ST, v);
    n_tests++;
    if (v !== exp_status(D, 1'b0, 1'b0)) begin
      n_fail++; $display("FAIL clear_overflow got=%h expected=%h", v, exp_status(D, 1'b0, 1'b0));
    end
    store(A_CT, 32'h1);
    line_start = cyc + 1;
    for (int t = 0; t < D * 10 * C + 2 * C; t++) begin
      tick();
      n_tests++;
      if (tx !== exp_tx(cyc) || busy !== exp_busy(cyc)) begin
        n_fail++;
        $display("FAIL drain_frames cyc=%0d tx=%b busy=%b expected tx=%b busy=%b",
                 cyc, tx, busy, exp_tx(cyc), exp_busy(cyc));
      end
    end
  endtask

  task automatic test_full_pop();
    logic [31:0] v;
    logic [7:0]  b;
    frames.delete();
    line_start = 1 << 30;
    store(A_CT, 32'h0);
    for (int i = 0; i < D; i++) begin
      b = 8'($urandom);
      frames.push_back(b);
      store(A_TX, {24'h0, b});
    end
    store(A_CT, 32'h1);
    line_start = cyc + 1;
    b = 8'($urandom);
    frames.push_back(b);
    store(A_TX, {24'h0, b});
    read_reg(A_ST, v);
    n_tests++;
    if (v !== exp_status(D, 1'b1, 1'b0)) begin
      n_fail++; $display("FAIL push_on_pop_status got=%h expected=%h", v, exp_status(D, 1'b1, 1'b0));
    end
    for (int t = 0; t < (D + 1) * 10 * C + 2 * C; t++) begin
      tick();
      n_tests++;
      if (tx !== exp_tx(cyc) || busy !== exp_busy(cyc)) begin
        n_fail++;
        $display("FAIL push_on_pop_line cyc=%0d tx=%b busy=%b expected tx=%b busy=%b",
                 cyc, tx, busy, exp_tx(cyc), exp_busy(cyc));
      end
    end
  endtask

  task automatic test_flush();
    logic [31:0] v;
    store(A_CT, 32'h0);
    for (int i = 0; i < 3; i++) store(A_TX, 32'($urandom));
    read_reg(A_ST, v);
    n_tests++;
    if (v !== exp_status(3, 1'b0, 1'b0)) begin
      n_fail++; $display("FAIL pre_flush got=%h expected=%h", v, exp_status(3, 1'b0, 1'b0));
    end
    store(A_CT, 32'h2);
    read_reg(A_ST, v);
    n_tests++;
    if (v !== exp_status(0, 1'b0, 1'b0)) begin
      n_fail++; $display("FAIL post_flush got=%h expected=%h", v, exp_status(0, 1'b0, 1'b0));
    end
    store(A_CT, 32'h1);
    for (int t = 0; t < 3 * C; t++) begin
      tick();
      n_tests++;
      if (tx !== 1'b1 || busy !== 1'b0) begin
        n_fail++; $display("FAIL flush_idle cyc=%0d tx=%b busy=%b expected tx=1 busy=0", cyc, tx, busy);
      end
    end
  endtask

  task automatic test_unmapped();
    logic [31:0] v;
    logic [31:0] rd_addrs [5];
    logic [31:0] wr_addrs [4];
    rd_addrs = '{BASE + 32'd12, 32'h1234_5678, A_TX, A_CT, 32'h7FFF_0004};
    wr_addrs = '{BASE + 32'd12, 32'h7FFF_0000, 32'h7FFF_0008, A_ST};
    for (int i = 0; i < 5; i++) begin
      read_reg(rd_addrs[i], v);
      n_tests++;
      if (v !== 32'h0) begin
        n_fail++; $display("FAIL unmapped_read addr=%h got=%h expected=0", rd_addrs[i], v);
      end
    end
    for (int i = 0; i < 4; i++) store(wr_addrs[i], {$urandom} & 32'hFFFF_FFF8 | 32'h6);
    for (int t = 0; t < 3 * C; t++) begin
      tick();
      n_tests++;
      if (tx !== 1'b1 || busy !== 1'b0) begin
        n_fail++; $display("FAIL unmapped_idle cyc=%0d tx=%b busy=%b expected tx=1 busy=0", cyc, tx, busy);
      end
    end
    read_reg(A_ST, v);
    n_tests++;
    if (v !== exp_status(0, 1'b0, 1'b0)) begin
      n_fail++; $display("FAIL unmapped_status got=%h expected=%h", v, exp_status(0, 1'b0, 1'b0));
    end
  endtask

  task automatic test_reset_mid();
    logic [31:0] v;
    int          target;
    frames.delete();
    frames.push_back(8'($urandom) & 8'hF7);
    frames.push_back(8'($urandom));
    line_start = cyc + 2;
    store(A_TX, {24'h0, frames[0]});
    store(A_TX, {24'h0, frames[1]});
    target = line_start + 4 * C;
    for (int i = 0; i < 200 && cyc < target; i++) tick();
    n_tests++;
    if (cyc !== target || tx !== exp_tx(cyc)) begin
      n_fail++; $display("FAIL mid_data cyc=%0d tx=%b expected cyc=%0d tx=%b", cyc, tx, target, exp_tx(target));
    end
    reset = 1'b0;
    #1;
    n_tests++;
    if (tx !== 1'b1 || busy !== 1'b0) begin
      n_fail++; $display("FAIL async_reset tx=%b busy=%b expected tx=1 busy=0", tx, busy);
    end
    tick(); tick();
    reset = 1'b1;
    tick();
    read_reg(A_ST, v);
    n_tests++;
    if (v !== 32'h0000_0002) begin
      n_fail++; $display("FAIL post_reset_status got=%h expected=00000002", v);
    end
    for (int t = 0; t < 12 * C; t++) begin
      tick();
      n_tests++;
      if (tx !== 1'b1 || busy !== 1'b0) begin
        n_fail++; $display("FAIL no_resume cyc=%0d tx=%b busy=%b expected tx=1 busy=0", cyc, tx, busy);
      end
    end
  endtask

  initial begin
    test_reset();
    test_frames(1, 1'b1);
    test_frames(3, 1'b0);
    for (int k = 0; k < 3; k++) test_frames(int'($urandom_range(1, 4)), 1'b0);
    test_overflow();
    test_full_pop();
    test_flush();
    test_unmapped();
    test_frames(2, 1'b0);
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/mmio_uart_tx.md
# mmio_uart_tx

Memory-mapped serial transmitter on the processor data-memory write port. Stores to its address window push bytes into an internal FIFO, and a serializer drains them as 8N1 frames on `tx`. Loads return status through a combinational read path. Sits beside data memory in the top level, decoded off `DataAdr`, `WriteData` and `MemWrite`.

## Interface
- `BASE_ADDR`, default 32'hFFFF_0000: word-aligned base of the 3-register window.
- `DEPTH`, default 8: FIFO entries, power of two, ≥2.
- `CLKS_PER_BIT`, default 16: clock cycles per serial bit, ≥2.
- `clk` in 1: sole clock, rising edge.
- `reset` in 1: one clock; reset is asynchronous and active-low.
- `MemWrite` in 1: store strobe from the processor, one store per cycle.
- `DataAdr` in 32: byte address of the current access.
- `WriteData` in 32: store data.
- `ReadData` out 32: status readback, combinational from `DataAdr`.
- `tx` out 1: serial line, idle high.
- `busy` out 1: high while a frame is on the line.

## Operation
- Register map, offsets from `BASE_ADDR`:
  - +0 TXDATA: write-only. A store pushes `WriteData[7:0]`; bits [31:8] are ignored.
  - +4 STATUS: read-only. [0] full, [1] empty, [2] busy, [3] overflow (sticky), [15:8] count. Other bits are 0.
  - +8 CTRL: write-only. [0] enable; [1] flush (self-clearing); [2] clear overflow (self-clearing).
- Address match compares all 32 bits. Unmapped offsets and non-window addresses read 0; stores to them have no effect. Reads have no side effects.
- A push to a full FIFO is dropped and sets overflow.
- Exception: when full and a pop occurs in the same cycle, the push is accepted and count is unchanged.
- Count width is $clog2(DEPTH+1). Read and write pointers wrap modulo `DEPTH`.
- Flush empties the FIFO in one cycle. It does not abort a frame in flight. A push in the flush cycle is discarded.
- Enable resets to 1. Clearing it mid-frame lets the current frame finish; no further pops follow.
- Serializer FSM, one state per line phase:
  - IDLE → START when enabled and FIFO non-empty (pop on this edge).
  - START → DATA after `CLKS_PER_BIT` cycles.
  - DATA sends 8 bits, LSB first, each held `CLKS_PER_BIT` cycles, then → STOP.
  - STOP holds `tx` high `CLKS_PER_BIT` cycles. Next state is START with a pop if enabled and non-empty, otherwise IDLE.
- `tx` is driven directly from a flop; no combinational glitches.
- Reset values: `tx`=1, `busy`=0, FSM=IDLE, FIFO empty, count=0, overflow=0, enable=1. `ReadData` reflects these values.

## Timing
- A store is accepted at the rising edge where `MemWrite` is high and the address matches. Count and STATUS update visibly the following cycle.
- Push at edge N into an empty, idle, enabled block:
  - pop and `tx`↓ at edge N+1; `busy`↑ at edge N+1;
  - data bit 0 at N+1+`CLKS_PER_BIT`;
  - stop bit at N+1+9·`CLKS_PER_BIT`;
  - `busy`↓ at N+1+10·`CLKS_PER_BIT` if no further data.
- Back-to-back frames: the next start bit begins on the edge ending STOP, with zero idle cycles. Frame period is exactly 10·`CLKS_PER_BIT`.
- Asserting `reset` mid-frame forces `tx` high asynchronously and loses FIFO contents.

## Structure
- Package `mmio_uart_pkg` holds:
  - register offset constants (TXDATA, STATUS, CTRL);
  - STATUS and CTRL bit-index constants;
  - the serializer state enum (IDLE, START, DATA, STOP).
- Sub-module `sync_fifo`, parameterized width/depth, with push/pop/full/empty/count/flush. The top holds address decode, CTRL and STATUS, and the serializer FSM with baud and bit counters.

## Test plan
- With `CLKS_PER_BIT`=4, store 32'h0000_00A5 to +0 → `tx` low 4 cycles, then bits 1,0,1,0,0,1,0,1 at 4 cycles each, then high 4; `busy` high for 40 cycles.
- Store 3 bytes in consecutive cycles → STATUS count reads 2 one cycle after the first pop. Three frames in 120 cycles with no idle gap; empty=1 afterward.
- With CTRL enable=0, store 9 bytes (`DEPTH`=8) → full=1, count=8, overflow=1, `tx` stays high. Write CTRL=4 → overflow=0. Write CTRL=1 → eight frames follow.
- Full FIFO, push issued on the pop edge → count stays 8, overflow stays 0, the pushed byte is transmitted last.
- Assert `reset` low in the middle of the DATA phase → `tx`=1 immediately, STATUS reads 32'h0000_0002 after release, no frame resumes.
- Read +12 and an out-of-window address → `ReadData`=0. Store to them → no state change.
